// File: rtl/exwb_arbiter_pkg.sv
// Shared types and constants for the execute-stage write-back arbiter.
// Entry widths are fixed here; the top-level width parameters default to them.
package exwb_arbiter_pkg;

  localparam int unsigned WB_TAG_W    = 4;
  localparam int unsigned WB_COMMON_W = 32;

  localparam logic [WB_TAG_W-1:0] TAG_INVALID = '1;

  localparam int unsigned NUM_CH = 5;

  // Channel indices follow the EX_*_UNIT ordering.
  localparam logic [2:0] CH_ALU    = 3'd0;
  localparam logic [2:0] CH_FWD    = 3'd1;
  localparam logic [2:0] CH_JUMP   = 3'd2;
  localparam logic [2:0] CH_BRANCH = 3'd3;
  localparam logic [2:0] CH_MEM    = 3'd4;

  typedef struct packed {
    logic [WB_TAG_W-1:0]    tag;
    logic [WB_COMMON_W-1:0] val;
    logic [WB_COMMON_W-1:0] next_pc;
    logic                   cmp_res;
  } wb_entry_t;

  function automatic logic [2:0] next_ch(input logic [2:0] ch);
    return (ch == CH_MEM) ? CH_ALU : ch + 3'd1;
  endfunction

endpackage

// File: rtl/exwb_arbiter_fifo.sv
// Circular result queue for one execute channel: head/tail pointers, occupancy
// count, flush, and a "full" threshold below true capacity.
module wb_fifo #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FULL_AT = DEPTH - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          at_cap;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign at_cap  = (count == CW'(DEPTH));
  assign full    = (count >= CW'(FULL_AT));
  assign do_pop  = pop && !empty;
  // A full queue still accepts when its head leaves in the same cycle.
  assign do_push = push && (!at_cap || do_pop);
  assign drop    = push && at_cap && !do_pop && !flush;
  assign dout    = mem[head];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[tail] <= din;
  end

endmodule

// File: rtl/exwb_arbiter.sv
// Write-back arbiter: five per-channel result queues, round-robin selection,
// and a single registered broadcast toward the ROB and reservation stations.
module exwb_arbiter #(
  parameter int unsigned       TAG_W       = exwb_arbiter_pkg::WB_TAG_W,
  parameter int unsigned       COMMON_W    = exwb_arbiter_pkg::WB_COMMON_W,
  parameter logic [TAG_W-1:0]  TAG_INVALID = '1,
  parameter int unsigned       DEPTH       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [TAG_W-1:0]    alu_target,
  input  logic [COMMON_W-1:0] alu_result,
  input  logic [TAG_W-1:0]    fwd_target,
  input  logic [COMMON_W-1:0] fwd_result,
  input  logic [TAG_W-1:0]    jump_target,
  input  logic [COMMON_W-1:0] jump_ori_pc,
  input  logic [COMMON_W-1:0] jump_next_pc,
  input  logic [TAG_W-1:0]    branch_target,
  input  logic [COMMON_W-1:0] branch_next_pc,
  input  logic                branch_cmp_res,
  input  logic [TAG_W-1:0]    mem_target,
  input  logic [COMMON_W-1:0] mem_result,
  output logic                full [0:4],
  output logic                wb_valid,
  output logic [TAG_W-1:0]    wb_tag,
  output logic [2:0]          wb_kind,
  output logic [COMMON_W-1:0] wb_val,
  output logic [COMMON_W-1:0] wb_next_pc,
  output logic                wb_cmp_res,
  output logic                overflow
);

  import exwb_arbiter_pkg::*;

  localparam int unsigned EW = $bits(wb_entry_t);

  wb_entry_t         in_e   [NUM_CH];
  wb_entry_t         head_e [NUM_CH];
  wb_entry_t         sel;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] drop;
  logic              grant_any;
  logic              grant_ok;
  logic [2:0]        grant_ch;
  logic [2:0]        rr_ptr;

  // Unused fields of each channel are stored as zero.
  assign in_e[CH_ALU]    = '{tag: alu_target,    val: alu_result,  next_pc: '0,             cmp_res: 1'b0};
  assign in_e[CH_FWD]    = '{tag: fwd_target,    val: fwd_result,  next_pc: '0,             cmp_res: 1'b0};
  assign in_e[CH_JUMP]   = '{tag: jump_target,   val: jump_ori_pc, next_pc: jump_next_pc,   cmp_res: 1'b0};
  assign in_e[CH_BRANCH] = '{tag: branch_target, val: '0,          next_pc: branch_next_pc, cmp_res: branch_cmp_res};
  assign in_e[CH_MEM]    = '{tag: mem_target,    val: mem_result,  next_pc: '0,             cmp_res: 1'b0};

  assign grant_ok = grant_any && !flush;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push[i] = (in_e[i].tag != TAG_INVALID);
    assign pop[i]  = grant_ok && (grant_ch == 3'(i));

    wb_fifo #(
      .W       (EW),
      .DEPTH   (DEPTH),
      .FULL_AT (DEPTH - 1)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_e[i]),
      .dout  (head_e[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .drop  (drop[i])
    );
  end

  // First non-empty queue at or after rr_ptr, wrapping MEM back to ALU.
  always_comb begin
    logic [2:0] idx;
    grant_any = 1'b0;
    grant_ch  = rr_ptr;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 3'((32'(rr_ptr) + k) % NUM_CH);
      if (!grant_any && !empty[idx]) begin
        grant_any = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  assign sel = head_e[grant_ch];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_ok) begin
      rr_ptr <= next_ch(grant_ch);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_tag     <= TAG_INVALID;
      wb_kind    <= '0;
      wb_val     <= '0;
      wb_next_pc <= '0;
      wb_cmp_res <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (|drop) overflow <= 1'b1;
      if (grant_ok) begin
        wb_valid   <= 1'b1;
        wb_tag     <= sel.tag;
        wb_kind    <= grant_ch;
        wb_val     <= sel.val;
        wb_next_pc <= sel.next_pc;
        wb_cmp_res <= sel.cmp_res;
      end else begin
        wb_valid <= 1'b0;
        wb_tag   <= TAG_INVALID;
      end
    end
  end

endmodule

// File: tb/tb_exwb_arbiter.sv
// Scoreboard bench for exwb_arbiter: per-channel expected queues plus an
// optional expected grant-order queue, checked on every broadcast.
module tb_exwb_arbiter;

  import exwb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  alu_target, fwd_target, jump_target, branch_target, mem_target;
  logic [31:0] alu_result, fwd_result, jump_ori_pc, jump_next_pc, branch_next_pc, mem_result;
  logic        branch_cmp_res;
  logic        full [0:4];
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [2:0]  wb_kind;
  logic [31:0] wb_val;
  logic [31:0] wb_next_pc;
  logic        wb_cmp_res;
  logic        overflow;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  wb_entry_t   exp_q [5][$];
  logic [2:0]  ord_q [$];
  bit          record  = 1'b1;
  bit          alt_on  = 1'b0;
  bit          prev_valid = 1'b0;
  logic [2:0]  prev_kind  = '0;

  exwb_arbiter #(
    .TAG_W       (4),
    .COMMON_W    (32),
    .TAG_INVALID (4'hF),
    .DEPTH       (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alu_target     (alu_target),
    .alu_result     (alu_result),
    .fwd_target     (fwd_target),
    .fwd_result     (fwd_result),
    .jump_target    (jump_target),
    .jump_ori_pc    (jump_ori_pc),
    .jump_next_pc   (jump_next_pc),
    .branch_target  (branch_target),
    .branch_next_pc (branch_next_pc),
    .branch_cmp_res (branch_cmp_res),
    .mem_target     (mem_target),
    .mem_result     (mem_result),
    .full           (full),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .wb_kind        (wb_kind),
    .wb_val         (wb_val),
    .wb_next_pc     (wb_next_pc),
    .wb_cmp_res     (wb_cmp_res),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned pending();
    int unsigned s = ord_q.size();
    for (int k = 0; k < 5; k++) s += exp_q[k].size();
    return s;
  endfunction

  function automatic logic [4:0] full_vec();
    return {full[0], full[1], full[2], full[3], full[4]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    alu_target = TAG_INVALID;    alu_result = '0;
    fwd_target = TAG_INVALID;    fwd_result = '0;
    jump_target = TAG_INVALID;   jump_ori_pc = '0; jump_next_pc = '0;
    branch_target = TAG_INVALID; branch_next_pc = '0; branch_cmp_res = 1'b0;
    mem_target = TAG_INVALID;    mem_result = '0;
  endtask

  task automatic drv_alu(input logic [3:0] t, input logic [31:0] v);
    alu_target = t; alu_result = v;
    if (record) exp_q[0].push_back('{tag: t, val: v, next_pc: '0, cmp_res: 1'b0});
  endtask

  task automatic drv_fwd(input logic [3:0] t, input logic [31:0] v);
    fwd_target = t; fwd_result = v;
    if (record) exp_q[1].push_back('{tag: t, val: v, next_pc: '0, cmp_res: 1'b0});
  endtask

  task automatic drv_jump(input logic [3:0] t, input logic [31:0] ori, input logic [31:0] nxt);
    jump_target = t; jump_ori_pc = ori; jump_next_pc = nxt;
    if (record) exp_q[2].push_back('{tag: t, val: ori, next_pc: nxt, cmp_res: 1'b0});
  endtask

  task automatic drv_branch(input logic [3:0] t, input logic [31:0] nxt, input logic c);
    branch_target = t; branch_next_pc = nxt; branch_cmp_res = c;
    if (record) exp_q[3].push_back('{tag: t, val: '0, next_pc: nxt, cmp_res: c});
  endtask

  task automatic drv_mem(input logic [3:0] t, input logic [31:0] v);
    mem_target = t; mem_result = v;
    if (record) exp_q[4].push_back('{tag: t, val: v, next_pc: '0, cmp_res: 1'b0});
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (pending() != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain", 128'(pending()), 128'(0));
    step();
    step();
  endtask

  // Broadcast monitor: sampled mid-cycle, away from the registering edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        if (ord_q.size() > 0) check("order", 128'(wb_kind), 128'(ord_q.pop_front()));
        if (alt_on && prev_valid && (wb_kind == 3'd0 || wb_kind == 3'd4)) begin
          if (exp_q[(wb_kind == 3'd0) ? 4 : 0].size() >= 2)
            check("alternate", 128'(wb_kind != prev_kind), 128'(1));
        end
        if (wb_kind > 3'd4 || exp_q[wb_kind].size() == 0) begin
          check("spurious_wb", 128'(wb_valid), 128'(0));
        end else begin
          check("wb_entry", 128'({wb_tag, wb_val, wb_next_pc, wb_cmp_res}),
                128'(exp_q[wb_kind].pop_front()));
        end
      end else begin
        check("idle_tag", 128'(wb_tag), 128'(TAG_INVALID));
      end
      prev_valid <= wb_valid;
      prev_kind  <= wb_kind;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_full4;

    // Reset state
    idle();
    rst = 1'b1;
    step();
    step();
    check("rst_valid",   128'(wb_valid),   128'(0));
    check("rst_tag",     128'(wb_tag),     128'(4'hF));
    check("rst_kind",    128'(wb_kind),    128'(0));
    check("rst_val",     128'(wb_val),     128'(0));
    check("rst_nextpc",  128'(wb_next_pc), 128'(0));
    check("rst_cmp",     128'(wb_cmp_res), 128'(0));
    check("rst_ovf",     128'(overflow),   128'(0));
    check("rst_full",    128'(full_vec()), 128'(0));
    rst = 1'b0;
    step();

    // Single ALU result: two-edge latency, then idle
    drv_alu(4'd3, 32'h55);
    step();
    idle();
    @(negedge clk);
    check("lat_edge1", 128'(wb_valid), 128'(0));
    @(negedge clk);
    check("lat_edge2", 128'(wb_valid), 128'(1));
    step();
    wait_drain();

    // All five channels at once from rr_ptr = 0, then pointer wraps to ALU
    do_reset();
    drv_alu(4'd1, 32'hA1);
    drv_fwd(4'd2, 32'hB2);
    drv_jump(4'd3, 32'h300, 32'h304);
    drv_branch(4'd4, 32'h400, 1'b0);
    drv_mem(4'd5, 32'hE5);
    for (int k = 0; k < 5; k++) ord_q.push_back(3'(k));
    step();
    idle();
    wait_drain();
    drv_alu(4'd7, 32'h77);
    drv_mem(4'd8, 32'h88);
    ord_q.push_back(3'd0);
    ord_q.push_back(3'd4);
    step();
    idle();
    wait_drain();

    // Jump then branch field routing; non-tag outputs hold when idle
    drv_jump(4'd2, 32'h104, 32'h200);
    step();
    idle();
    drv_branch(4'd6, 32'h40, 1'b1);
    step();
    idle();
    wait_drain();
    check("hold_valid",  128'(wb_valid),   128'(0));
    check("hold_nextpc", 128'(wb_next_pc), 128'(32'h40));
    check("hold_cmp",    128'(wb_cmp_res), 128'(1));
    check("hold_val",    128'(wb_val),     128'(0));

    // ALU and MEM streaming with the issuer honouring full
    alt_on    = 1'b1;
    saw_full4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idle();
      if (full[4]) saw_full4 = 1'b1;
      if (!full[0]) drv_alu(4'(i % 15), 32'h1000 + 32'(i));
      if (!full[4]) drv_mem(4'((i + 7) % 15), 32'h2000 + 32'(i));
      step();
    end
    idle();
    wait_drain();
    alt_on = 1'b0;
    check("full4_seen",  128'(saw_full4), 128'(1));
    check("stream_ovf",  128'(overflow),  128'(0));

    // MEM overrun while the other four channels hold the grants
    do_reset();
    drv_alu(4'd1, 32'h11);
    drv_fwd(4'd2, 32'h22);
    drv_jump(4'd3, 32'h33, 32'h34);
    drv_branch(4'd4, 32'h44, 1'b1);
    drv_mem(4'd8, 32'h80);
    step();
    for (int j = 1; j <= 4; j++) begin
      idle();
      record = (j < 4);
      drv_mem(4'(8 + j), 32'h80 + 32'(j));
      step();
      record = 1'b1;
      if (j == 1) check("full4_cnt2", 128'(full[4]), 128'(0));
      if (j == 2) check("full4_cnt3", 128'(full[4]), 128'(1));
      if (j == 3) check("ovf_cnt4",   128'(overflow), 128'(0));
      if (j == 4) check("ovf_drop",   128'(overflow), 128'(1));
    end
    idle();
    wait_drain();
    check("ovf_sticky", 128'(overflow), 128'(1));
    do_reset();
    check("ovf_rst", 128'(overflow), 128'(0));

    // Flush with three entries queued and a same-cycle arrival
    record = 1'b0;
    drv_alu(4'd1, 32'hF1);
    drv_fwd(4'd2, 32'hF2);
    drv_jump(4'd3, 32'hF3, 32'hF4);
    step();
    idle();
    flush = 1'b1;
    drv_mem(4'd9, 32'hF9);
    step();
    idle();
    record = 1'b1;
    check("flush_valid", 128'(wb_valid),   128'(0));
    check("flush_full",  128'(full_vec()), 128'(0));
    repeat (6) step();
    drv_alu(4'd5, 32'h5A);
    ord_q.push_back(3'd0);
    step();
    idle();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
